seq_detect_ctrl: RTL and testbench

Controller that feeds a byte stream into a programmable serial pattern detector and schedules its operation. It accepts bytes over a valid/ready handshake and serializes them MSB-first, one bit per clock, into an internal history register. It compares the last `cfg_len` bits against a programmed pattern in overlapping or non-overlapping mode, and reports each hit as a one-cycle pulse plus a saturating count. It sits between a byte-wide producer and the status/interrupt logic, replacing hard-wired single-pattern Mealy detectors.

---
 rtl/seq_detect_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: accepts bytes over a valid/ready handshake, shifts them
// MSB-first into a history register one bit per clock, and flags every
// occurrence of a programmable pattern (overlapping or non-overlapping).
// A saturating counter tracks the hits since the last start.
module seq_detect_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SHIFT
    } state_t;

    // Power-up configuration: pattern 1011, four bits, non-overlapping.
    localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(4'b1011);
    localparam logic [3:0]         RST_LEN = 4'd4;
    localparam logic [3:0]         FILL_MAX = 4'(MAX_LEN);

    // Control state
    state_t             state_q,     state_d;
    logic               stop_pend_q, stop_pend_d;
    logic [7:0]         byte_q,      byte_d;
    logic [2:0]         idx_q,       idx_d;

    // Detector state
    logic [MAX_LEN-1:0] hist_q,      hist_d;
    logic [3:0]         fill_q,      fill_d;

    // Configuration
    logic [MAX_LEN-1:0] pat_q,       pat_d;
    logic [3:0]         len_q,       len_d;
    logic               ovl_q,       ovl_d;

    // Registered outputs
    logic               match_q,     match_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_q,       err_d;

    // Per-bit detector evaluation
    logic               bit_cur;
    logic [MAX_LEN-1:0] hist_n;
    logic [3:0]         fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic               cfg_len_ok;

    // Evaluate the bit the SHIFT state would consume this cycle.
    always_comb begin
        bit_cur  = byte_q[idx_q];
        hist_n   = {hist_q[MAX_LEN-2:0], bit_cur};
        fill_n   = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + 4'd1;
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
        hit        = (fill_n >= len_q) && ((hist_n & len_mask) == (pat_q & len_mask));
        cfg_len_ok = (cfg_len != 4'd0) && (cfg_len <= FILL_MAX);
    end

    // Next-state logic for the scheduler, detector and configuration.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        byte_d      = byte_q;
        idx_d       = idx_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        pat_d       = pat_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        match_d     = 1'b0;
        cnt_d       = cnt_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (cfg_len_ok) begin
                        pat_d = cfg_pattern;
                        len_d = cfg_len;
                        ovl_d = cfg_overlap;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    hist_d      = '0;
                    fill_d      = '0;
                    stop_pend_d = 1'b0;
                end
            end

            ST_RUN: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end
                // stop wins over a same-cycle handshake
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    byte_d  = in_data;
                    idx_d   = 3'd7;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end
                hist_d = hist_n;
                fill_d = (hit && !ovl_q) ? 4'd0 : fill_n;
                if (hit) begin
                    match_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    // a stop arriving with the last bit is honoured directly
                    // rather than being latched and then lost to the clear
                    state_d     = (stop_pend_q || stop) ? ST_IDLE : ST_RUN;
                    stop_pend_d = 1'b0;
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset of everything, configuration included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            byte_q      <= '0;
            idx_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= RST_PAT;
            len_q       <= RST_LEN;
            ovl_q       <= 1'b0;
            match_q     <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            byte_q      <= byte_d;
            idx_q       <= idx_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            match_q     <= match_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // Output decode
    always_comb begin
        in_ready    = (state_q == ST_RUN);
        busy        = (state_q != ST_IDLE);
        match       = match_q;
        match_count = cnt_q;
        cfg_err     = err_q;
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a queue-based behavioural model checked against
// the DUT every cycle, directed scenarios with hand-computed expectations,
// then randomized traffic. A second instance with a 2-bit counter covers
// saturation.
module tb_seq_detect_ctrl;

    localparam int ML = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [3:0]    cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;

    logic          in_ready, match, busy, cfg_err;
    logic [CW-1:0] match_count;
    logic          s_in_ready, s_match, s_busy, s_cfg_err;
    logic [1:0]    s_count;

    seq_detect_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) u_dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .match(match),
        .match_count(match_count), .busy(busy), .cfg_err(cfg_err)
    );

    seq_detect_ctrl #(.MAX_LEN(ML), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready), .match(s_match),
        .match_count(s_count), .busy(s_busy), .cfg_err(s_cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Run flag plus a queue of bits still to be consumed; history kept as an
    // integer, pattern matched with modular arithmetic.
    int     cyc = 0;
    bit     m_run, m_pend, m_match, m_err, m_ovl;
    int     m_hist, m_fill, m_pat, m_len;
    longint m_cnt;
    bit     mq[$];

    initial begin
        bit b;
        forever begin
            @(posedge clk or negedge reset_n);
            if (clk) cyc++;
            if (!reset_n) begin
                m_run = 0; m_pend = 0; m_match = 0; m_err = 0;
                m_hist = 0; m_fill = 0; m_cnt = 0;
                m_pat = 'hB; m_len = 4; m_ovl = 0;
                mq.delete();
            end else begin
                m_match = 0;
                m_err   = 0;
                if (!m_run) begin
                    if (cfg_we) begin
                        if (cfg_len >= 1 && cfg_len <= ML) begin
                            m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
                        end else begin
                            m_err = 1;
                        end
                    end
                    if (start) begin
                        m_run = 1; m_cnt = 0; m_hist = 0; m_fill = 0; m_pend = 0;
                    end
                end else begin
                    if (cfg_we) m_err = 1;
                    if (mq.size() == 0) begin
                        if (stop) m_run = 0;
                        else if (in_valid)
                            for (int i = 7; i >= 0; i--) mq.push_back(in_data[i]);
                    end else begin
                        b = mq.pop_front();
                        m_hist = ((m_hist * 2) + b) % (1 << ML);
                        m_fill = (m_fill + 1 > ML) ? ML : m_fill + 1;
                        if (m_fill >= m_len && (m_hist % (1 << m_len)) == (m_pat % (1 << m_len))) begin
                            m_match = 1;
                            m_cnt++;
                            if (!m_ovl) m_fill = 0;
                        end
                        if (stop) m_pend = 1;
                        if (mq.size() == 0) begin
                            if (m_pend) m_run = 0;
                            m_pend = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en  = 0;
    int pulses  = 0;
    int last_mc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (match) begin
                pulses++;
                last_mc = cyc;
            end
            if (cmp_en) begin
                chk("in_ready", in_ready, m_run && (mq.size() == 0));
                chk("busy", busy, m_run);
                chk("match", match, m_match);
                chk("cfg_err", cfg_err, m_err);
                chk("match_count", match_count, (m_cnt > 65535) ? 65535 : m_cnt);
                chk("sat_count", s_count, (m_cnt > 3) ? 3 : m_cnt);
                chk("sat_match", s_match, m_match);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output int hs);
        int n = 0;
        while (!(m_run && mq.size() == 0) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("send_ready_timeout", 0, 1);
        in_valid = 1'b1; in_data = b;
        tick();
        hs = cyc;
        in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs, h2, p0;
        bit seen;

        do_reset();
        cmp_en = 1;

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_match", match, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_count", match_count, 0);

        // default pattern 1011 on 0xB0
        do_start();
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        p0 = pulses;
        send(8'hB0, hs);
        repeat (7) tick();
        chk("b0_ready_h7", in_ready, 0);
        tick();
        chk("b0_ready_h8", in_ready, 1);
        tick();
        chk("b0_pulses", pulses - p0, 1);
        chk("b0_match_at", last_mc - hs, 4);
        chk("b0_count", match_count, 1);
        do_stop();
        chk("stop_busy", busy, 0);

        // 101 / len 3 on 0xA8, non-overlap then overlap
        do_cfg(8'h05, 4'd3, 1'b0);
        do_start();
        send(8'hA8, hs);
        repeat (10) tick();
        chk("a8_novl_count", match_count, 1);
        chk("a8_novl_at", last_mc - hs, 3);
        do_stop();
        do_cfg(8'h05, 4'd3, 1'b1);
        do_start();
        send(8'hA8, hs);
        repeat (10) tick();
        chk("a8_ovl_count", match_count, 2);
        chk("a8_ovl_at", last_mc - hs, 5);
        do_stop();

        // pattern straddling a byte boundary
        do_cfg(8'h0B, 4'd4, 1'b0);
        do_start();
        p0 = pulses;
        send(8'h01, hs);
        send(8'h60, h2);
        repeat (10) tick();
        chk("xbyte_pulses", pulses - p0, 1);
        chk("xbyte_count", match_count, 1);
        chk("xbyte_at", last_mc - h2, 3);

        // configuration write while busy is rejected
        send(8'h00, hs);
        tick(); tick();
        do_cfg(8'h05, 4'd3, 1'b1);
        chk("busy_cfg_err", cfg_err, 1);
        tick();
        chk("busy_cfg_err_clr", cfg_err, 0);
        send(8'hB0, hs);
        repeat (10) tick();
        chk("busy_cfg_count", match_count, 2);
        chk("busy_cfg_at", last_mc - hs, 4);
        do_stop();

        // zero length rejected in IDLE; eight ones with len 8
        do_cfg(8'h0B, 4'd0, 1'b0);
        chk("len0_err", cfg_err, 1);
        do_cfg(8'hFF, 4'd8, 1'b0);
        do_start();
        send(8'hFF, hs);
        repeat (10) tick();
        chk("ff_count", match_count, 1);
        chk("ff_at", last_mc - hs, 8);

        // stop during the third SHIFT cycle
        send(8'h00, hs);
        tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        seen = 0;
        repeat (4) begin seen |= in_ready; tick(); end
        chk("stopshift_busy_h7", busy, 1);
        seen |= in_ready;
        tick();
        chk("stopshift_busy_h8", busy, 0);
        seen |= in_ready;
        chk("stopshift_no_ready", seen, 0);

        // stop together with in_valid in RUN
        do_start();
        stop = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        tick();
        stop = 1'b0; in_valid = 1'b0;
        chk("stopvalid_busy", busy, 0);
        repeat (10) tick();
        chk("stopvalid_count", match_count, 0);

        // asynchronous reset mid-SHIFT restores default config
        do_cfg(8'h05, 4'd3, 1'b1);
        do_start();
        send(8'hB0, hs);
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_match", match, 0);
        chk("arst_count", match_count, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        do_start();
        send(8'hB0, hs);
        repeat (10) tick();
        chk("arst_cfg_count", match_count, 1);
        chk("arst_cfg_at", last_mc - hs, 4);

        // four hits: 16-bit counter reads 4, 2-bit counter holds at 3
        do_stop();
        do_start();
        send(8'hBB, hs);
        send(8'hBB, hs);
        repeat (10) tick();
        chk("sat_main", match_count, 4);
        chk("sat_hold", s_count, 3);
        do_stop();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start       = ($urandom % 16) == 0;
            stop        = ($urandom % 24) == 0;
            cfg_we      = ($urandom % 20) == 0;
            cfg_len     = 4'($urandom_range(0, 9));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom);
            in_valid    = ($urandom % 3) != 0;
            in_data     = 8'($urandom);
            reset_n     = ($urandom % 500) != 0;
            tick();
        end
        start = 0; stop = 0; cfg_we = 0; in_valid = 0; reset_n = 1;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
